pwm_duty_decoder: RTL
=====================

// Module: pwm_duty_decoder
// PURPOSE
//  Downstream checker for the PWM stage. Samples pwm_signal and its 195 kHz frame clock
//  on clk_3125KHz and recovers the 4-bit duty code of each completed frame.
//  Flags malformed frames: wrong period, more than one high pulse, or a lost frame clock.
//  Used for self-test and closed-loop confirmation of the duty code that was commanded.
// PARAMETERS
//  DUTY_W   4   duty code width; PERIOD must equal 2**DUTY_W
//  PERIOD   16  clk_3125KHz cycles per frame
//  TIMEOUT  32  cycles without a frame start before lock is dropped (> PERIOD)
// PORTS
//  clk_3125KHz  in   1       sample clock, rising edge; the only clock
//  rst_n        in   1       asynchronous, active-low reset
//  clk_195KHz   in   1       frame clock from the PWM stage; its rising edge starts a frame
//  pwm_signal   in   1       PWM waveform from the PWM stage
//  duty_out     out  DUTY_W  high-sample count of the last good frame
//  duty_valid   out  1       1-cycle pulse: duty_out/full_on updated
//  full_on      out  1       last good frame was high for all PERIOD samples
//  glitch_err   out  1       1-cycle pulse: closed frame contained more than one high run
//  period_err   out  1       1-cycle pulse: closed frame length != PERIOD
//  locked       out  1       high while frames arrive with correct period
// BEHAVIOUR
//  Reset (async assert, sync release): all outputs 0, state SYNC, counters 0.
//   frm_q/frm_qq reset to 1; a frame clock already high at release is not a frame start.
//  Input stage: pwm_q <= pwm_signal, frm_q <= clk_195KHz, frm_qq <= frm_q every edge.
//   fs = frm_q & ~frm_qq. The pwm_q sample in the fs cycle is sample 0 of the new frame.
//  Per-frame counters, cleared to the fs-cycle contribution at fs:
//   cyc_cnt: samples in the frame; saturates at TIMEOUT.
//   hi_cnt (DUTY_W+1 bits): samples with pwm_q=1.
//   runs (2 bits, saturating): counts a sample where pwm_q=1 and (sample 0 or previous pwm_q=0).
//  FSM:
//   SYNC: on fs -> MEASURE and open a frame. No outputs change.
//   MEASURE: on fs, close the current frame, open the next one, and apply one rule:
//    cyc_cnt==PERIOD and runs<=1: duty_valid=1, duty_out=hi_cnt[DUTY_W-1:0],
//     full_on=(hi_cnt==PERIOD), locked=1.
//    cyc_cnt==PERIOD and runs>1: glitch_err=1; duty_out/full_on held; no valid.
//    cyc_cnt!=PERIOD: period_err=1, locked=0; no valid; state stays MEASURE.
//   MEASURE with cyc_cnt reaching TIMEOUT and no fs: locked=0, -> SYNC. No error pulse.
//  Latency: the clk_195KHz rising edge registered by the PWM stage at edge E is detected
//   after E+1. Status pulses appear after E+2 and last exactly one cycle.
//  Full frame (hi_cnt==PERIOD): duty_out=0 and full_on=1.
//   Zero duty: duty_out=0, full_on=0, runs=0. Both are valid.
//  Frame clock duty is not checked; only its rising edges matter.
//  Reset mid-frame: the partial frame is discarded. The first duty_valid comes at the 2nd fs after release.
// TESTING
//  1. Reset, then drive the PWM stage with duty 5 for 4 frames.
//     -> duty_valid from the 2nd fs onward every 16 cycles; duty_out=5; locked=1.
//  2. Sweep duty 0..15, one code per 3 frames -> duty_out tracks each code.
//     The frame after a code change may still report the old code. full_on stays 0.
//  3. Force pwm_signal=1 for whole frames -> duty_out=0, full_on=1, duty_valid pulses, no errors.
//  4. Inject a 1-cycle low inside a high run at duty 10 -> glitch_err pulse at the next fs.
//     No duty_valid; duty_out stays 10.
//  5. Insert an extra fs 9 cycles into a frame -> period_err pulse and locked=0.
//     The next 16-cycle frame gives duty_valid and locked=1.
//  6. Stop clk_195KHz for 40 cycles -> locked=0 at cycle TIMEOUT, no pulses, state SYNC.
//     Restart the clock -> first duty_valid at the 2nd fs. Assert rst_n mid-frame -> all outputs 0 at once.

Source files
------------

// File: rtl/pwm_duty_decoder.sv
// Recovers the duty code of each PWM frame delimited by the frame clock and flags
// malformed frames: wrong length, more than one high run, or a lost frame clock.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  SYNC    | waiting for the first frame start; no frame is open
//  MEASURE | a frame is open; each frame start closes it and opens the next
module pwm_duty_decoder #(
  parameter int DUTY_W  = 4,
  parameter int PERIOD  = 16,
  parameter int TIMEOUT = 32
) (
  input  logic              clk_3125KHz,
  input  logic              rst_n,
  input  logic              clk_195KHz,
  input  logic              pwm_signal,
  output logic [DUTY_W-1:0] duty_out,
  output logic              duty_valid,
  output logic              full_on,
  output logic              glitch_err,
  output logic              period_err,
  output logic              locked
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int HI_W  = DUTY_W + 1;

  typedef enum logic {
    SYNC    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t            state_q;
  logic              pwm_q;
  logic              pwm_qq;
  logic              frm_q;
  logic              frm_qq;
  logic [CNT_W-1:0]  cyc_cnt_q, cyc_cnt_d;
  logic [HI_W-1:0]   hi_cnt_q, hi_cnt_d;
  logic [1:0]        runs_q, runs_d;
  logic              fs;
  logic              run_start;
  logic              period_ok;
  logic              timed_out;

  // Frame-clock history resets high so a clock already high at release is not a start.
  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q  <= 1'b0;
      pwm_qq <= 1'b0;
      frm_q  <= 1'b1;
      frm_qq <= 1'b1;
    end else begin
      pwm_q  <= pwm_signal;
      pwm_qq <= pwm_q;
      frm_q  <= clk_195KHz;
      frm_qq <= frm_q;
    end
  end

  assign fs        = frm_q & ~frm_qq;
  assign run_start = pwm_q & (fs | ~pwm_qq);
  assign period_ok = (cyc_cnt_q == CNT_W'(PERIOD));
  assign timed_out = (cyc_cnt_q == CNT_W'(TIMEOUT));

  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    hi_cnt_d  = hi_cnt_q;
    runs_d    = runs_q;
    if (fs) begin
      cyc_cnt_d = CNT_W'(1);
      hi_cnt_d  = {{(HI_W-1){1'b0}}, pwm_q};
      runs_d    = {1'b0, pwm_q};
    end else begin
      if (!timed_out) begin
        cyc_cnt_d = cyc_cnt_q + 1'b1;
      end
      // Saturate so an overlong frame cannot wrap back to a plausible count.
      if (pwm_q && (hi_cnt_q != {HI_W{1'b1}})) begin
        hi_cnt_d = hi_cnt_q + 1'b1;
      end
      if (run_start && (runs_q != 2'b11)) begin
        runs_d = runs_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt_q <= '0;
      hi_cnt_q  <= '0;
      runs_q    <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
      hi_cnt_q  <= hi_cnt_d;
      runs_q    <= runs_d;
    end
  end

  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SYNC;
      duty_out   <= '0;
      duty_valid <= 1'b0;
      full_on    <= 1'b0;
      glitch_err <= 1'b0;
      period_err <= 1'b0;
      locked     <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      glitch_err <= 1'b0;
      period_err <= 1'b0;
      case (state_q)
        SYNC: begin
          if (fs) begin
            state_q <= MEASURE;
          end
        end
        MEASURE: begin
          if (fs) begin
            if (period_ok && (runs_q <= 2'd1)) begin
              duty_valid <= 1'b1;
              duty_out   <= hi_cnt_q[DUTY_W-1:0];
              full_on    <= (hi_cnt_q == HI_W'(PERIOD));
              locked     <= 1'b1;
            end else if (period_ok) begin
              glitch_err <= 1'b1;
            end else begin
              period_err <= 1'b1;
              locked     <= 1'b0;
            end
          end else if (timed_out) begin
            // Frame clock lost: drop lock quietly and resynchronise.
            locked  <= 1'b0;
            state_q <= SYNC;
          end
        end
        default: state_q <= SYNC;
      endcase
    end
  end

endmodule
